// File: rtl/fir_pkg.sv
// Shared widths, FSM/tag types and the round-robin pick for the FIR frame arbiter.
package fir_pkg;

  localparam int FIR_IN_W  = 19;
  localparam int FIR_OUT_W = 36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] ch;
    logic       last;
  } fir_tag_t;

  // First requester after 'last' in circular order over n channels; 0 if none.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last, input int n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = (int'(last) + i) % n;
      if (!found && (i <= n) && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fir_tag_delay.sv
// Fixed-depth shift register carrying sample tags alongside the filter pipeline.
module fir_tag_delay
  import fir_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     clr,
  input  fir_tag_t tag_in,
  output fir_tag_t tag_out
);

  fir_tag_t stage_q [DEPTH];

  // Shift one stage per cycle; clr empties the whole line.
  always_ff @(posedge clk) begin
    if (clr) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/fir_frame_arbiter.sv
// Frame-granular round-robin sharing of one FIR datapath with channel/last tagging.
// Define FIR_ARB_FLUSH_EN to append TAPS-1 zero samples after every frame.
module fir_frame_arbiter
  import fir_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int FRAME_LEN = 128,
  parameter int TAPS      = 16,
  parameter int FILT_LAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH*FIR_IN_W-1:0] req_data,
  output logic [N_CH-1:0]          req_ready,
  output logic [FIR_IN_W-1:0]      flt_in,
  output logic                     flt_valid,
  input  logic [FIR_OUT_W-1:0]     flt_out,
  input  logic                     flt_vout,
  output logic                     out_valid,
  output logic [FIR_OUT_W-1:0]     out_data,
  output logic [2:0]               out_ch,
  output logic                     out_last,
  output logic                     busy,
  output logic                     tag_err
);

`ifdef FIR_ARB_FLUSH_EN
  localparam logic FLUSH_EN = 1'b1;
`else
  localparam logic FLUSH_EN = 1'b0;
`endif

  localparam int              CNT_W    = $clog2(FRAME_LEN);
  localparam int              FC_W     = $clog2(TAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(TAPS - 2);
  localparam logic [N_CH-1:0]  ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};

  arb_state_t            state_q;
  logic [2:0]            grant_q;
  logic [2:0]            last_grant_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [FC_W-1:0]       fcnt_q;
  logic [N_CH-1:0]       req_ready_q;
  logic [FIR_IN_W-1:0]   flt_in_q;
  logic                  flt_valid_q;
  fir_tag_t              tag_q;
  logic                  busy_q;
  logic                  out_valid_q;
  logic [FIR_OUT_W-1:0]  out_data_q;
  logic [2:0]            out_ch_q;
  logic                  out_last_q;
  logic                  tag_err_q;

  logic [2:0]            pick_s;
  logic [FIR_IN_W-1:0]   sel_data_s;
  logic                  xfer_s;
  fir_tag_t              tag_end_s;

  assign pick_s = rr_pick(8'(req_valid), last_grant_q, N_CH);
  // req_ready_q is one-hot on the grant while streaming, so this is the grant's handshake.
  assign xfer_s = |(req_valid & req_ready_q);

  // Select the granted channel's sample lane.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_data_s = sel_data_s |
                   ((grant_q == 3'(i)) ? req_data[i*FIR_IN_W +: FIR_IN_W] : {FIR_IN_W{1'b0}});
    end
  end

  // Arbitration FSM; every filter-facing output and the pushed tag are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 3'd0;
      last_grant_q <= 3'(N_CH - 1);
      cnt_q        <= '0;
      fcnt_q       <= '0;
      req_ready_q  <= '0;
      flt_in_q     <= '0;
      flt_valid_q  <= 1'b0;
      tag_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          flt_in_q    <= '0;
          flt_valid_q <= 1'b0;
          tag_q       <= '0;
          if (|req_valid) begin
            grant_q      <= pick_s;
            last_grant_q <= pick_s;
            cnt_q        <= '0;
            req_ready_q  <= ONE_HOT0 << pick_s;
            busy_q       <= 1'b1;
            state_q      <= STREAM;
          end
        end
        STREAM: begin
          if (xfer_s) begin
            flt_in_q    <= sel_data_s;
            flt_valid_q <= 1'b1;
            tag_q       <= '{valid: 1'b1, ch: grant_q, last: (!FLUSH_EN && (cnt_q == CNT_LAST))};
            if (cnt_q == CNT_LAST) begin
              cnt_q       <= '0;
              fcnt_q      <= '0;
              req_ready_q <= '0;
              busy_q      <= FLUSH_EN;
              state_q     <= FLUSH_EN ? FLUSH : IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            flt_valid_q <= 1'b0;
            tag_q       <= '0;
          end
        end
        FLUSH: begin
          flt_in_q    <= '0;
          flt_valid_q <= 1'b1;
          tag_q       <= '{valid: 1'b1, ch: grant_q, last: (fcnt_q == FC_LAST)};
          if (fcnt_q == FC_LAST) begin
            fcnt_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            fcnt_q <= fcnt_q + FC_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= '0;
          flt_valid_q <= 1'b0;
          tag_q       <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  fir_tag_delay #(
    .DEPTH (FILT_LAT)
  ) u_tag_delay (
    .clk     (clk),
    .clr     (rst),
    .tag_in  (tag_q),
    .tag_out (tag_end_s)
  );

  // Result register: the tag emerging with flt_out decides validity; flt_vout only audits it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= 3'd0;
      out_last_q  <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      out_valid_q <= tag_end_s.valid;
      tag_err_q   <= tag_err_q | (flt_vout != tag_end_s.valid);
      if (tag_end_s.valid) begin
        out_data_q <= flt_out;
        out_ch_q   <= tag_end_s.ch;
        out_last_q <= tag_end_s.last;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign flt_in    = flt_in_q;
  assign flt_valid = flt_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign tag_err   = tag_err_q;

endmodule
